dmem_access_unit: RTL

Data-memory access unit for the MEM stage of the RV32IM pipeline, sitting directly upstream of the MEM/WB pipeline register. It accepts load/store requests from the EX/MEM register and runs a multi-cycle request/acknowledge handshake with data memory. It formats load data (byte/half/word, signed/unsigned) into the value latched by MEM/WB as DMEM_OUT. It drives the global BUSYWAIT stall that freezes every pipeline register while an access is in flight.

---
 rtl/dmem_access_unit.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/dmem_access_unit.sv
// MEM-stage data memory access unit: req/ack handshake with data memory,
// store lane steering, load formatting and the global pipeline stall.
module dmem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ_EN,
  input  logic        WRITE_EN,
  input  logic [2:0]  FUNC3,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] DATA_OUT,
  output logic        BUSYWAIT,
  output logic        MISALIGNED,
  output logic        BUS_ERROR,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [29:0] MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  output logic [3:0]  MEM_BYTE_EN,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_ACK
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;

  logic        req;
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        mis;
  logic        start;
  logic [3:0]  be_n;
  logic [31:0] wd_n;

  logic        q_byte;
  logic        q_half;
  logic        q_word;
  logic        sx;
  logic [31:0] rd_sh;
  logic [31:0] ld_n;

  assign req     = READ_EN | WRITE_EN;
  assign is_byte = ~FUNC3[1] & ~FUNC3[0];
  assign is_half = ~FUNC3[1] &  FUNC3[0];
  assign is_word =  FUNC3[1];

  assign mis = (is_half & ADDRESS[0]) |
               (is_word & (|ADDRESS[1:0]));

  assign MISALIGNED = req & mis;
  assign start      = (state == IDLE) & req & ~mis;
  assign BUSYWAIT   = start | (state == ACCESS);

  always_comb begin
    be_n = 4'b0000;
    wd_n = 32'h0;
    unique case (1'b1)
      is_byte: begin
        be_n = 4'b0001 << ADDRESS[1:0];
        wd_n = {4{WRITE_DATA[7:0]}};
      end
      is_half: begin
        be_n = ADDRESS[1] ? 4'b1100 : 4'b0011;
        wd_n = {2{WRITE_DATA[15:0]}};
      end
      is_word: begin
        be_n = 4'b1111;
        wd_n = WRITE_DATA;
      end
    endcase
  end

  // Load lane selection uses the access shape latched at request time.
  assign q_byte = ~f3_q[1] & ~f3_q[0];
  assign q_half = ~f3_q[1] &  f3_q[0];
  assign q_word =  f3_q[1];
  assign sx     = ~f3_q[2];
  assign rd_sh  = MEM_READDATA >> {off_q, 3'b000};

  always_comb begin
    ld_n = MEM_READDATA;
    unique case (1'b1)
      q_byte: ld_n = {{24{sx & rd_sh[7]}}, rd_sh[7:0]};
      q_half: ld_n = {{16{sx & rd_sh[15]}}, rd_sh[15:0]};
      q_word: ld_n = MEM_READDATA;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state         <= IDLE;
      cnt           <= '0;
      f3_q          <= 3'b000;
      off_q         <= 2'b00;
      DATA_OUT      <= 32'h0;
      BUS_ERROR     <= 1'b0;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= 30'h0;
      MEM_WRITEDATA <= 32'h0;
      MEM_BYTE_EN   <= 4'b0000;
    end else begin
      BUS_ERROR <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            MEM_READ      <= READ_EN & ~WRITE_EN;
            MEM_WRITE     <= WRITE_EN;
            MEM_ADDRESS   <= ADDRESS[31:2];
            MEM_WRITEDATA <= wd_n;
            MEM_BYTE_EN   <= be_n;
            f3_q          <= FUNC3;
            off_q         <= ADDRESS[1:0];
            cnt           <= '0;
            state         <= ACCESS;
          end else if (req) begin
            DATA_OUT <= 32'h0;
          end
        end
        ACCESS: begin
          if (MEM_ACK) begin
            DATA_OUT  <= MEM_WRITE ? 32'h0 : ld_n;
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
            state     <= DONE;
          end else if (cnt == CNT_LAST) begin
            DATA_OUT  <= 32'h0;
            BUS_ERROR <= 1'b1;
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
            state     <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
